// File: rtl/axis_pkg.sv
// Shared AXI-Stream helpers for the width converters.
// Keep widths, counter sizing, width legality and the two-state output FSM type.
package axis_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  function automatic int keep_width(input int w);
    return w / 8;
  endfunction

  function automatic int cnt_bits(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

  function automatic bit widths_ok(input int iw, input int ow);
    return (iw > 0) && (iw % 8 == 0) &&
           (ow >= iw) && (ow % iw == 0);
  endfunction

endpackage

// File: rtl/axis_upsizer.sv
// Packs narrow AXI-Stream beats into wide words for the array's S_AXIS port.
// Little-endian lane order; TLAST closes a word early with zero-filled lanes.
module axis_upsizer
  import axis_pkg::*;
#(
  parameter int inWidth  = 64,
  parameter int outWidth = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [inWidth-1:0]      S_AXIS_TDATA,
  input  logic [inWidth/8-1:0]    S_AXIS_TKEEP,
  input  logic                    S_AXIS_TLAST,
  input  logic                    S_AXIS_TVALID,
  output logic                    S_AXIS_TREADY,
  output logic [outWidth-1:0]     M_AXIS_TDATA,
  output logic [outWidth/8-1:0]   M_AXIS_TKEEP,
  output logic                    M_AXIS_TLAST,
  output logic                    M_AXIS_TVALID,
  input  logic                    M_AXIS_TREADY,
  output logic                    short_frame,
  output logic                    keep_err
);

  localparam int ratio    = outWidth / inWidth;
  localparam int cntWidth = cnt_bits(ratio);
  localparam int inKeep   = keep_width(inWidth);
  localparam int outKeep  = keep_width(outWidth);

  localparam logic [cntWidth-1:0] lastIdx =
    cntWidth'(ratio - 1);

  generate
    if (!widths_ok(inWidth, outWidth)) begin : g_bad_widths
      $error("axis_upsizer: illegal inWidth/outWidth");
    end
  endgenerate

  state_t                state;
  logic [cntWidth-1:0]   cnt;
  logic [outWidth-1:0]   buf_data;
  logic [outKeep-1:0]    buf_keep;
  logic [outWidth-1:0]   merged_data;
  logic [outKeep-1:0]    merged_keep;

  logic s_ready;
  logic accept;
  logic at_last;
  logic complete;
  logic drain;

  assign M_AXIS_TVALID = (state == FULL);
  assign s_ready       = (state == EMPTY) || M_AXIS_TREADY;
  assign S_AXIS_TREADY = s_ready;
  assign accept        = S_AXIS_TVALID && s_ready;
  assign at_last       = (cnt == lastIdx);
  assign complete      = accept &&
                         (S_AXIS_TLAST || at_last);
  assign drain         = M_AXIS_TVALID && M_AXIS_TREADY;

  // Buffer with the current beat dropped into lane cnt.
  // Lanes above cnt are still zero from the last clear.
  always_comb begin
    merged_data = buf_data;
    merged_keep = buf_keep;
    for (int i = 0; i < ratio; i++) begin
      if (cnt == cntWidth'(i)) begin
        merged_data[i*inWidth +: inWidth] = S_AXIS_TDATA;
        merged_keep[i*inKeep +: inKeep]   = S_AXIS_TKEEP;
      end
    end
  end

  // Assembly buffer and lane counter; cleared on every completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      buf_data <= '0;
      buf_keep <= '0;
    end else if (accept) begin
      if (complete) begin
        cnt      <= '0;
        buf_data <= '0;
        buf_keep <= '0;
      end else begin
        cnt      <= cnt + cntWidth'(1);
        buf_data <= merged_data;
        buf_keep <= merged_keep;
      end
    end
  end

  // Output FSM with registered word, TLAST and short-frame pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= EMPTY;
      M_AXIS_TDATA <= '0;
      M_AXIS_TKEEP <= '0;
      M_AXIS_TLAST <= 1'b0;
      short_frame  <= 1'b0;
    end else begin
      short_frame <= 1'b0;
      if (complete) begin
        state        <= FULL;
        M_AXIS_TDATA <= merged_data;
        M_AXIS_TKEEP <= merged_keep;
        M_AXIS_TLAST <= S_AXIS_TLAST;
        short_frame  <= S_AXIS_TLAST && !at_last;
      end else if (drain) begin
        state <= EMPTY;
      end
    end
  end

  // Sticky flag for a partial-keep beat in the middle of a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      keep_err <= 1'b0;
    end else if (accept && !S_AXIS_TLAST &&
                 !(&S_AXIS_TKEEP)) begin
      keep_err <= 1'b1;
    end
  end

endmodule
